// File: rtl/servo_360_sequenciador.sv
// Face-turn command sequencer for the continuous-rotation servo drivers.
// Queues {servo, quarter turns}, fires one iniciar pulse per quarter turn, waits for pronto, settles, and traps stuck drivers.
module servo_360_sequenciador #(
  parameter int N_SERVOS     = 6,
  parameter int FIFO_DEPTH   = 8,
  parameter int PAUSA_CICLOS = 50000,
  parameter int TIMEOUT      = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_servo,
  input  logic [1:0]          cmd_quartos,
  output logic                cmd_ready,
  input  logic [N_SERVOS-1:0] pronto_servo,
  input  logic                limpa_erro,
  output logic [N_SERVOS-1:0] iniciar,
  output logic                ocupado,
  output logic                fila_vazia,
  output logic                erro,
  output logic [2:0]          db_estado
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [N_SERVOS-1:0] UM = 1;

  typedef enum logic [2:0] {
    OCIOSO  = 3'b000,
    DISPARA = 3'b001,
    ESPERA  = 3'b010,
    PAUSA   = 3'b011,
    ERRO    = 3'b111
  } estado_t;

  estado_t       estado;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    servo_at;
  logic [1:0]    restante;
  logic [31:0]   cnt;

  logic       push, pop, full, pronto_sel, head_ok;
  logic [2:0] head_servo;
  logic [1:0] head_quartos;

  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign cmd_ready    = !full;
  assign fila_vazia   = (count == '0);
  assign push         = cmd_valid && cmd_ready;
  assign pop          = (estado == OCIOSO) && !fila_vazia;
  assign {head_servo, head_quartos} = mem[rd_ptr];
  assign head_ok      = (head_quartos != 2'd0) && (32'(head_servo) < 32'(N_SERVOS));
  assign pronto_sel   = |(pronto_servo & (UM << servo_at));

  assign ocupado   = (estado != OCIOSO);
  assign erro      = (estado == ERRO);
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {cmd_servo, cmd_quartos};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // iniciar is registered on every transition into DISPARA so it is high exactly while in DISPARA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      servo_at <= '0;
      restante <= '0;
      cnt      <= '0;
      iniciar  <= '0;
    end else begin
      iniciar <= '0;
      case (estado)
        OCIOSO: begin
          if (pop) begin
            servo_at <= head_servo;
            restante <= head_quartos;
            if (head_ok) begin
              estado  <= DISPARA;
              iniciar <= UM << head_servo;
            end
          end
        end
        DISPARA: begin
          cnt    <= '0;
          estado <= ESPERA;
        end
        ESPERA: begin
          if (pronto_sel) begin
            restante <= restante - 2'd1;
            cnt      <= '0;
            estado   <= PAUSA;
          end else begin
            cnt <= cnt + 32'd1;
            if (cnt == 32'(TIMEOUT - 1)) estado <= ERRO;
          end
        end
        PAUSA: begin
          if (cnt == 32'(PAUSA_CICLOS - 1)) begin
            cnt <= '0;
            if (restante != 2'd0) begin
              estado  <= DISPARA;
              iniciar <= UM << servo_at;
            end else begin
              estado <= OCIOSO;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ERRO: begin
          restante <= '0;
          if (limpa_erro) estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_360_sequenciador.sv
// Self-checking bench for servo_360_sequenciador: scoreboard of expected pulses plus
// table-driven FIFO fill and hand-written watchdog/reset sequences.
module tb_servo_360_sequenciador;

  localparam int NS = 6;
  localparam int FD = 8;
  localparam int P  = 5;
  localparam int T  = 40;
  localparam int GAP = 10 + 1 + P + 1;

  logic          clock = 0;
  logic          reset;
  logic          cmd_valid;
  logic [2:0]    cmd_servo;
  logic [1:0]    cmd_quartos;
  logic          cmd_ready;
  logic [NS-1:0] pronto_servo;
  logic          limpa_erro;
  logic [NS-1:0] iniciar;
  logic          ocupado, fila_vazia, erro;
  logic [2:0]    db_estado;

  servo_360_sequenciador #(
    .N_SERVOS(NS), .FIFO_DEPTH(FD), .PAUSA_CICLOS(P), .TIMEOUT(T)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_servo(cmd_servo),
    .cmd_quartos(cmd_quartos), .cmd_ready(cmd_ready), .pronto_servo(pronto_servo),
    .limpa_erro(limpa_erro), .iniciar(iniciar), .ocupado(ocupado),
    .fila_vazia(fila_vazia), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int sb[$];
  int pulse_cyc[$];
  bit auto_pronto = 0;

  typedef struct {
    int servo;
    int quartos;
    bit rdy_before;
    int rdy_after;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Pulse monitor: every iniciar pulse must match the head of the scoreboard
  initial begin
    logic [NS-1:0] prev_ini;
    logic prev_ocu;
    int e;
    prev_ini = '0;
    prev_ocu = 0;
    forever begin
      @(negedge clock);
      if (iniciar != '0) begin
        chk("pulse_width", prev_ini, 0);
        pulse_cyc.push_back(cyc);
        if (sb.size() == 0) chk("unexpected_pulse", iniciar, 0);
        else begin
          e = sb.pop_front();
          chk("pulse_order", iniciar, 1 << e);
        end
      end
      if (prev_ocu && !ocupado) fall_cyc = cyc;
      prev_ini = iniciar;
      prev_ocu = ocupado;
    end
  end

  // Driver model: answers each pulse with pronto sampled 12 edges after the pulse edge
  initial begin
    logic [NS-1:0] s;
    pronto_servo = '0;
    forever begin
      @(negedge clock);
      if (auto_pronto && iniciar != '0) begin
        s = iniciar;
        repeat (11) @(posedge clock);
        #1 pronto_servo = s;
        @(posedge clock);
        #1 pronto_servo = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic push(input int s, input int q, input bit rdy_before, input int rdy_after);
    cmd_servo = 3'(s);
    cmd_quartos = 2'(q);
    cmd_valid = 1;
    @(negedge clock);
    chk("ready_before_push", cmd_ready, rdy_before);
    @(posedge clock);
    #1 cmd_valid = 0;
    if (rdy_before && q != 0 && s < NS)
      for (int i = 0; i < q; i++) sb.push_back(s);
    if (rdy_after >= 0) chk("ready_after_push", cmd_ready, rdy_after);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(ocupado == 0 && fila_vazia == 1) && n < 2000);
    chk({nm, "_idle_reached"}, n < 2000, 1);
    chk({nm, "_sb_drained"}, sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_iniciar"}, iniciar, 0);
    chk({nm, "_ocupado"}, ocupado, 0);
    chk({nm, "_erro"}, erro, 0);
    chk({nm, "_fila_vazia"}, fila_vazia, 1);
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
    chk({nm, "_db_estado"}, db_estado, 0);
  endtask

  initial begin
    vec_t fill [FD];
    vec_t inval [2];
    int n;
    fill[0] = '{0, 1, 1'b1, 1};
    fill[1] = '{1, 2, 1'b1, 1};
    fill[2] = '{3, 1, 1'b1, 1};
    fill[3] = '{2, 1, 1'b1, 1};
    fill[4] = '{4, 1, 1'b1, 1};
    fill[5] = '{5, 1, 1'b1, 1};
    fill[6] = '{1, 1, 1'b1, 1};
    fill[7] = '{0, 1, 1'b1, 0};
    inval[0] = '{7, 1, 1'b1, 1};
    inval[1] = '{1, 0, 1'b1, 1};

    reset = 0;
    cmd_valid = 0;
    cmd_servo = '0;
    cmd_quartos = '0;
    limpa_erro = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock);
    #1 reset = 1;

    // Three quarter turns on servo 2 with pulse spacing and latency
    auto_pronto = 1;
    pulse_cyc.delete();
    push(2, 3, 1, 1);
    chk("t1_fila_vazia_after_push", fila_vazia, 0);
    @(posedge clock);
    @(negedge clock);
    chk("t1_dispara_latency", db_estado, 1);
    chk("t1_iniciar_latency", iniciar, 1 << 2);
    @(posedge clock);
    #1;
    wait_idle("t1");
    chk("t1_pulse_count", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("t1_gap_1_2", pulse_cyc[1] - pulse_cyc[0], GAP);
      chk("t1_gap_2_3", pulse_cyc[2] - pulse_cyc[1], GAP);
      chk("t1_ocupado_fall", fall_cyc - pulse_cyc[2], GAP);
    end

    // Fill the FIFO while busy, reject a 9th command, drain in order
    push(5, 1, 1, 1);
    for (int i = 0; i < FD; i++)
      push(fill[i].servo, fill[i].quartos, fill[i].rdy_before, fill[i].rdy_after);
    push(4, 1, 0, 0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cmd_ready && n < 200);
    chk("fill_ready_returns", cmd_ready, 1);
    chk("fill_ready_after_pop_state", db_estado, 1);
    @(posedge clock);
    #1;
    wait_idle("fill");

    // Invalid commands are discarded silently
    for (int i = 0; i < 2; i++) begin
      push(inval[i].servo, inval[i].quartos, inval[i].rdy_before, inval[i].rdy_after);
      @(negedge clock);
      chk("inval_fila_not_empty", fila_vazia, 0);
      @(posedge clock);
      @(negedge clock);
      chk("inval_state_ocioso", db_estado, 0);
      chk("inval_fila_vazia", fila_vazia, 1);
      chk("inval_no_pulse", iniciar, 0);
      chk("inval_not_busy", ocupado, 0);
      @(posedge clock);
      #1;
    end

    // Watchdog: pronto withheld, limpa_erro outside ERRO ignored
    auto_pronto = 0;
    push(3, 1, 1, -1);
    push(1, 1, 1, -1);
    limpa_erro = 1;
    repeat (2) @(posedge clock);
    #1 limpa_erro = 0;
    repeat (T - 2) @(posedge clock);
    @(negedge clock);
    chk("wd_still_espera", db_estado, 3'b010);
    chk("wd_no_erro_yet", erro, 0);
    @(posedge clock);
    @(negedge clock);
    chk("wd_erro_state", db_estado, 3'b111);
    chk("wd_erro_flag", erro, 1);
    chk("wd_erro_busy", ocupado, 1);
    chk("wd_fifo_retained", fila_vazia, 0);
    @(posedge clock);
    #1;
    push(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("wd_erro_holds", db_estado, 3'b111);
      chk("wd_erro_no_pulse", iniciar, 0);
    end
    @(posedge clock);
    #1 auto_pronto = 1;
    limpa_erro = 1;
    @(posedge clock);
    #1 limpa_erro = 0;
    @(negedge clock);
    chk("wd_cleared_ocioso", db_estado, 0);
    chk("wd_cleared_erro", erro, 0);
    @(negedge clock);
    chk("wd_next_cmd_dispara", db_estado, 1);
    chk("wd_next_cmd_pulse", iniciar, 1 << 1);
    @(posedge clock);
    #1;
    wait_idle("wd");

    // pronto on the exact expiry cycle wins; pronto in DISPARA and foreign pronto ignored
    auto_pronto = 0;
    push(4, 1, 1, -1);
    @(posedge clock);
    #1 pronto_servo = (1 << 4) | (1 << 3);
    @(posedge clock);
    #1 pronto_servo = 1 << 3;
    @(negedge clock);
    chk("race_dispara_pronto_ignored", db_estado, 3'b010);
    @(posedge clock);
    #1 pronto_servo = '0;
    @(negedge clock);
    chk("race_foreign_pronto_ignored", db_estado, 3'b010);
    repeat (T - 2) @(posedge clock);
    #1 pronto_servo = 1 << 4;
    @(negedge clock);
    chk("race_pre_expiry_espera", db_estado, 3'b010);
    @(posedge clock);
    #1 pronto_servo = '0;
    @(negedge clock);
    chk("race_pausa_entered", db_estado, 3'b011);
    chk("race_no_erro", erro, 0);
    @(posedge clock);
    #1;
    wait_idle("race");

    // Asynchronous reset during ESPERA with three commands queued
    push(2, 1, 1, -1);
    push(3, 1, 1, -1);
    push(4, 1, 1, -1);
    push(5, 1, 1, -1);
    @(negedge clock);
    chk("rst_pre_espera", db_estado, 3'b010);
    chk("rst_pre_queued", fila_vazia, 0);
    #2 reset = 0;
    #1;
    chk_reset_outputs("rst_async");
    sb.delete();
    @(posedge clock);
    #1 reset = 1;
    repeat (30) @(negedge clock);
    chk("rst_after_ocioso", db_estado, 0);
    chk("rst_after_empty", fila_vazia, 1);
    chk("rst_after_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
